// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and helpers for the matmul job sequencer
package matmul_pkg;

  localparam int MATRIXSIZE_W = 16;

  typedef logic [2*MATRIXSIZE_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } mmseq_state_t;

  // Element count of one operand: tiles * array edge * inner dimension.
  function automatic cnt_t dim_product(input logic [MATRIXSIZE_W-1:0] a, input int n,
                                       input logic [MATRIXSIZE_W-1:0] b);
    return cnt_t'(a) * cnt_t'(n) * cnt_t'(b);
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// rtl/matmul_seq_ctrl_if.sv - job, element-stream and array-read signals; out_ready under MMSEQ_OUT_STALL_EN
interface matmul_seq_ctrl_if #(
  parameter int MATRIXSIZE_W = matmul_pkg::MATRIXSIZE_W
);
  logic                    start;
  logic [MATRIXSIZE_W-1:0] M1dN1;
  logic [MATRIXSIZE_W-1:0] M2;
  logic [MATRIXSIZE_W-1:0] M3dN2;
  logic                    busy;
  logic                    done;
  logic                    in_valid;
  logic                    in_ready;
  logic                    valid_A;
  logic                    valid_B;
  logic                    rd_en;
  logic [MATRIXSIZE_W-1:0] rd_k;
  logic [MATRIXSIZE_W-1:0] rd_ta;
  logic [MATRIXSIZE_W-1:0] rd_tb;
  logic                    acc_clr;
  logic                    acc_last;
`ifdef MMSEQ_OUT_STALL_EN
  logic                    out_ready;

  modport master (
    output start, M1dN1, M2, M3dN2, in_valid, out_ready,
    input  busy, done, in_ready, valid_A, valid_B, rd_en, rd_k, rd_ta, rd_tb, acc_clr, acc_last
  );
  modport slave (
    input  start, M1dN1, M2, M3dN2, in_valid, out_ready,
    output busy, done, in_ready, valid_A, valid_B, rd_en, rd_k, rd_ta, rd_tb, acc_clr, acc_last
  );
`else
  modport master (
    output start, M1dN1, M2, M3dN2, in_valid,
    input  busy, done, in_ready, valid_A, valid_B, rd_en, rd_k, rd_ta, rd_tb, acc_clr, acc_last
  );
  modport slave (
    input  start, M1dN1, M2, M3dN2, in_valid,
    output busy, done, in_ready, valid_A, valid_B, rd_en, rd_k, rd_ta, rd_tb, acc_clr, acc_last
  );
`endif
endinterface

// File: rtl/matmul_seq_ctrl_tile_iter.sv
// rtl/matmul_seq_ctrl_tile_iter.sv - k/tb/ta nested counter driving tile-ordered array reads
module tile_iter #(
  parameter int W = matmul_pkg::MATRIXSIZE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] k_max,
  input  logic [W-1:0] tb_max,
  input  logic [W-1:0] ta_max,
  output logic [W-1:0] k,
  output logic [W-1:0] tb,
  output logic [W-1:0] ta,
  output logic         k_last,
  output logic         wrap
);
  import matmul_pkg::*;

  logic tb_last;
  logic ta_last;

  assign k_last  = (k == k_max);
  assign tb_last = (tb == tb_max);
  assign ta_last = (ta == ta_max);
  assign wrap    = en & k_last & tb_last & ta_last;

  // The final wrap leaves all three indices at zero for the next job.
  always_ff @(posedge clk) begin
    if (rst) begin
      k  <= '0;
      tb <= '0;
      ta <= '0;
    end else if (en) begin
      if (k_last) begin
        k <= '0;
        if (tb_last) begin
          tb <= '0;
          ta <= ta_last ? '0 : ta + 1'b1;
        end else begin
          tb <= tb + 1'b1;
        end
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - load A, load B, tile compute, drain, done; MMSEQ_OUT_STALL_EN adds out_ready backpressure
module matmul_seq_ctrl #(
  parameter int MATRIXSIZE_W = matmul_pkg::MATRIXSIZE_W,
  parameter int N1           = 4,
  parameter int N2           = 4,
  parameter int PIPE_LAT     = 8
) (
  input  logic               clk,
  input  logic               rst,
  matmul_seq_ctrl_if.slave   bus
);
  import matmul_pkg::*;

  localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
  localparam logic [2:0] S_LOAD_A  = 3'(ST_LOAD_A);
  localparam logic [2:0] S_LOAD_B  = 3'(ST_LOAD_B);
  localparam logic [2:0] S_COMPUTE = 3'(ST_COMPUTE);
  localparam logic [2:0] S_DRAIN   = 3'(ST_DRAIN);
  localparam logic [2:0] S_DONE    = 3'(ST_DONE);

  logic [2:0]              state;
  cnt_t                    a_total;
  cnt_t                    b_total;
  cnt_t                    beat_cnt;
  cnt_t                    drain_cnt;
  logic [MATRIXSIZE_W-1:0] k_max;
  logic [MATRIXSIZE_W-1:0] tb_max;
  logic [MATRIXSIZE_W-1:0] ta_max;
  logic [MATRIXSIZE_W-1:0] it_k;
  logic [MATRIXSIZE_W-1:0] it_tb;
  logic [MATRIXSIZE_W-1:0] it_ta;
  logic                    it_en;
  logic                    it_k_last;
  logic                    it_wrap;
  logic                    out_ok;
  logic                    loading;
  logic                    accept;
  logic                    beat_last;
  logic                    zero_dim;

`ifdef MMSEQ_OUT_STALL_EN
  assign out_ok = bus.out_ready;
`else
  assign out_ok = 1'b1;
`endif

  assign zero_dim  = (bus.M1dN1 == '0) | (bus.M2 == '0) | (bus.M3dN2 == '0);
  assign loading   = (state == S_LOAD_A) | (state == S_LOAD_B);
  assign accept    = bus.in_valid & loading;
  assign beat_last = (state == S_LOAD_A) ? (beat_cnt == a_total - cnt_t'(1))
                                         : (beat_cnt == b_total - cnt_t'(1));
  assign it_en     = (state == S_COMPUTE) & out_ok;

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.in_ready = loading;
  assign bus.valid_A  = accept & (state == S_LOAD_A);
  assign bus.valid_B  = accept & (state == S_LOAD_B);
  assign bus.rd_en    = it_en;
  assign bus.rd_k     = it_k;
  assign bus.rd_ta    = it_ta;
  assign bus.rd_tb    = it_tb;
  assign bus.acc_clr  = it_en & (it_k == '0);
  assign bus.acc_last = it_en & it_k_last;

  tile_iter #(.W(MATRIXSIZE_W)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .en     (it_en),
    .k_max  (k_max),
    .tb_max (tb_max),
    .ta_max (ta_max),
    .k      (it_k),
    .tb     (it_tb),
    .ta     (it_ta),
    .k_last (it_k_last),
    .wrap   (it_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a_total   <= '0;
      b_total   <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      k_max     <= '0;
      tb_max    <= '0;
      ta_max    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_total <= dim_product(bus.M1dN1, N1, bus.M2);
            b_total <= dim_product(bus.M3dN2, N2, bus.M2);
            k_max   <= bus.M2 - 1'b1;
            tb_max  <= bus.M3dN2 - 1'b1;
            ta_max  <= bus.M1dN1 - 1'b1;
            state   <= zero_dim ? S_DONE : S_LOAD_A;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (accept) begin
            if (beat_last) begin
              beat_cnt <= '0;
              state    <= (state == S_LOAD_A) ? S_LOAD_B : S_COMPUTE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (it_wrap) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Only cycles the consumer accepts count toward the drain window.
          if (out_ok) begin
            if (drain_cnt == cnt_t'(PIPE_LAT - 1)) begin
              drain_cnt <= '0;
              state     <= S_DONE;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - scoreboard bench for matmul_seq_ctrl; stall scenario under MMSEQ_OUT_STALL_EN
module tb_matmul_seq_ctrl;
  localparam int W        = 16;
  localparam int N1       = 4;
  localparam int N2       = 4;
  localparam int PIPE_LAT = 8;

  typedef struct packed {
    logic [W-1:0] k;
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    logic         clr;
    logic         last;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic    exp_beat[$];
  rd_exp_t exp_rd[$];

  matmul_seq_ctrl_if #(.MATRIXSIZE_W(W)) bus ();

  matmul_seq_ctrl #(.MATRIXSIZE_W(W), .N1(N1), .N2(N2), .PIPE_LAT(PIPE_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic iv(input int t, input int gap);
    return (gap != 0) ? (t % 2 == 1) : 1'b1;
  endfunction

  task automatic test_reset();
    logic [3*W+10:0] all_out;
    rst = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b1;
    bus.M1dN1 = 16'd1; bus.M2 = 16'd1; bus.M3dN2 = 16'd1;
`ifdef MMSEQ_OUT_STALL_EN
    bus.out_ready = 1'b1;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    all_out = {bus.busy, bus.done, bus.in_ready, bus.valid_A, bus.valid_B, bus.rd_en,
               bus.rd_k, bus.rd_ta, bus.rd_tb, bus.acc_clr, bus.acc_last, 5'd0};
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Drives one job starting at cycle 0 and scores every cycle against the queues.
  task automatic run_job(input logic [W-1:0] m1, input logic [W-1:0] m2, input logic [W-1:0] m3,
                         input int gap, input int stall_at, input int misuse_at, input string tag);
    int atot, btot, ncomp, nst, last_beat, t_done, n, t;
    logic zero, exp_rdy, exp_bt, in_win, stalled, exp_rd_en, isa;
    rd_exp_t r;
    atot  = int'(m1) * N1 * int'(m2);
    btot  = int'(m2) * int'(m3) * N2;
    ncomp = int'(m1) * int'(m2) * int'(m3);
    nst   = (stall_at >= 0) ? 3 : 0;
    zero  = (m1 == 0) || (m2 == 0) || (m3 == 0);
    exp_beat.delete(); exp_rd.delete();
    if (zero) begin
      last_beat = 0;
      t_done    = 1;
    end else begin
      for (int i = 0; i < atot; i++) exp_beat.push_back(1'b1);
      for (int i = 0; i < btot; i++) exp_beat.push_back(1'b0);
      for (int a = 0; a < int'(m1); a++)
        for (int b = 0; b < int'(m3); b++)
          for (int k = 0; k < int'(m2); k++)
            exp_rd.push_back('{k: W'(k), ta: W'(a), tb: W'(b),
                               clr: (k == 0), last: (k == int'(m2) - 1)});
      n = 0; t = 0;
      while (n < atot + btot) begin
        t++;
        if (iv(t, gap)) n++;
      end
      last_beat = t;
      t_done    = last_beat + 1 + ncomp + nst + PIPE_LAT;
    end
    for (int cyc = 0; cyc <= t_done + 3; cyc++) begin
      @(posedge clk); #1;
      bus.start    = (cyc == 0) || (cyc == misuse_at);
      bus.M1dN1    = (cyc == 0) ? m1 : 16'd7;
      bus.M2       = (cyc == 0) ? m2 : 16'd7;
      bus.M3dN2    = (cyc == 0) ? m3 : 16'd7;
      bus.in_valid = iv(cyc, gap);
      stalled      = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 3);
`ifdef MMSEQ_OUT_STALL_EN
      bus.out_ready = !stalled;
`endif
      @(negedge clk);
      exp_rdy   = !zero && (cyc >= 1) && (cyc <= last_beat);
      exp_bt    = exp_rdy && iv(cyc, gap);
      in_win    = !zero && (cyc > last_beat) && (cyc <= last_beat + ncomp + nst);
      exp_rd_en = in_win && !stalled;
      vectors += 5;
      if (bus.busy !== ((cyc >= 1) && (cyc <= t_done))) begin
        miscompares++;
        $display("FAIL %s busy cyc=%0d got=%b", tag, cyc, bus.busy);
      end
      if (bus.done !== (cyc == t_done)) begin
        miscompares++;
        $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, cyc, bus.done, cyc == t_done);
      end
      if (bus.in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL %s in_ready cyc=%0d got=%b exp=%b", tag, cyc, bus.in_ready, exp_rdy);
      end
      if ((bus.valid_A | bus.valid_B) !== exp_bt) begin
        miscompares++;
        $display("FAIL %s beat cyc=%0d got=%b%b exp_any=%b", tag, cyc, bus.valid_A, bus.valid_B, exp_bt);
      end
      if (bus.rd_en !== exp_rd_en) begin
        miscompares++;
        $display("FAIL %s rd_en cyc=%0d got=%b exp=%b", tag, cyc, bus.rd_en, exp_rd_en);
      end
      if (exp_bt && exp_beat.size() > 0) begin
        isa = exp_beat.pop_front();
        vectors++;
        if ({bus.valid_A, bus.valid_B} !== {isa, !isa}) begin
          miscompares++;
          $display("FAIL %s beat_dest cyc=%0d got=%b%b exp_A=%b", tag, cyc, bus.valid_A, bus.valid_B, isa);
        end
      end
      if (exp_rd_en && exp_rd.size() > 0) begin
        r = exp_rd.pop_front();
        vectors++;
        if ({bus.rd_k, bus.rd_ta, bus.rd_tb, bus.acc_clr, bus.acc_last} !== r) begin
          miscompares++;
          $display("FAIL %s rd_tuple cyc=%0d got k=%0d ta=%0d tb=%0d clr=%b last=%b exp k=%0d ta=%0d tb=%0d clr=%b last=%b",
                   tag, cyc, bus.rd_k, bus.rd_ta, bus.rd_tb, bus.acc_clr, bus.acc_last,
                   r.k, r.ta, r.tb, r.clr, r.last);
        end
      end else if (stalled && in_win && exp_rd.size() > 0) begin
        vectors++;
        if ({bus.rd_k, bus.acc_clr, bus.acc_last} !== {exp_rd[0].k, 2'b00}) begin
          miscompares++;
          $display("FAIL %s stall_hold cyc=%0d got k=%0d clr=%b last=%b exp k=%0d", tag, cyc,
                   bus.rd_k, bus.acc_clr, bus.acc_last, exp_rd[0].k);
        end
      end else if (!in_win) begin
        vectors++;
        if ({bus.rd_k, bus.rd_ta, bus.rd_tb} !== '0) begin
          miscompares++;
          $display("FAIL %s rd_idx_idle cyc=%0d got k=%0d ta=%0d tb=%0d", tag, cyc, bus.rd_k, bus.rd_ta, bus.rd_tb);
        end
      end
    end
    bus.start = 1'b0;
    vectors++;
    if (exp_beat.size() != 0 || exp_rd.size() != 0) begin
      miscompares++;
      $display("FAIL %s leftover got beats=%0d rd=%0d exp 0", tag, exp_beat.size(), exp_rd.size());
    end
  endtask

  task automatic test_basic();
    run_job(16'd1, 16'd2, 16'd1, 0, -1, -1, "basic");
  endtask

  task automatic test_stream_gaps();
    run_job(16'd1, 16'd2, 16'd1, 1, -1, -1, "gaps");
  endtask

  task automatic test_tile_order();
    run_job(16'd2, 16'd3, 16'd2, 0, -1, -1, "tiles");
  endtask

  task automatic test_zero_dim();
    run_job(16'd1, 16'd0, 16'd1, 0, -1, -1, "zero_m2");
    run_job(16'd0, 16'd2, 16'd1, 0, -1, -1, "zero_m1");
  endtask

  task automatic test_start_misuse();
    run_job(16'd1, 16'd2, 16'd1, 0, -1, 12, "misuse");
  endtask

  task automatic test_reset_mid_job();
    logic [3*W+5:0] all_out;
    for (int cyc = 0; cyc <= 18; cyc++) begin
      @(posedge clk); #1;
      bus.start    = (cyc == 0);
      bus.M1dN1    = 16'd1; bus.M2 = 16'd2; bus.M3dN2 = 16'd1;
      bus.in_valid = 1'b1;
      rst          = (cyc == 17);
      @(negedge clk);
      if (cyc == 17) begin
        vectors++;
        if (bus.rd_en !== 1'b1) begin
          miscompares++;
          $display("FAIL rst_mid in_compute got rd_en=%b exp=1", bus.rd_en);
        end
      end
      if (cyc == 18) begin
        all_out = {bus.busy, bus.done, bus.in_ready, bus.valid_A, bus.valid_B, bus.rd_en,
                   bus.rd_k, bus.rd_ta, bus.rd_tb, bus.acc_clr, bus.acc_last};
        vectors++;
        if (all_out !== '0) begin
          miscompares++;
          $display("FAIL rst_mid outputs got=%h exp=0", all_out);
        end
      end
    end
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        miscompares++;
        $display("FAIL rst_mid no_done cyc=%0d got busy=%b done=%b exp 00", cyc, bus.busy, bus.done);
      end
    end
    run_job(16'd1, 16'd2, 16'd1, 0, -1, -1, "after_rst");
  endtask

  task automatic test_out_stall();
`ifdef MMSEQ_OUT_STALL_EN
    run_job(16'd1, 16'd2, 16'd1, 0, 18, -1, "stall_short");
    run_job(16'd2, 16'd3, 16'd2, 0, 55, -1, "stall_tiles");
`else
    run_job(16'd2, 16'd1, 16'd3, 0, -1, -1, "k_one");
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.M1dN1 = '0; bus.M2 = '0; bus.M3dN2 = '0;
`ifdef MMSEQ_OUT_STALL_EN
    bus.out_ready = 1'b1;
`endif
    test_reset();
    test_basic();
    test_stream_gaps();
    test_tile_order();
    test_zero_dim();
    test_start_misuse();
    test_reset_mid_job();
    test_out_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
